// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the receiver state encoding.
package uart_pkg;

   // Defaults shared by the receiver, transmitter and baud-rate generator.
   localparam int NB_DATA_DEF      = 8;
   localparam int N_OVERSAMPLE_DEF = 16;
   localparam int N_STOP_TICKS_DEF = 16;

   // One-hot receiver states.
   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      START = 4'b0010,
      DATA  = 4'b0100,
      STOP  = 4'b1000
   } state_t;

   // Larger of two integers, used to size counters shared by two limits.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Two-stage capture; both stages reset to the line's idle level.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         meta_r <= RESET_VAL;
         sync_r <= RESET_VAL;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver: start detect, centre sampling of data bits
// (LSB first), stop-bit check with framing error flag, one-cycle done pulse.
module uart_rx
   import uart_pkg::*;
#(
   parameter int NB_DATA      = NB_DATA_DEF,
   parameter int N_OVERSAMPLE = N_OVERSAMPLE_DEF,
   parameter int N_STOP_TICKS = N_STOP_TICKS_DEF
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_rx,
   input  logic               i_tick,
   output logic [NB_DATA-1:0] o_rx_data,
   output logic               o_rx_done,
   output logic               o_frame_err
);

   localparam int TICK_W = $clog2(max_int(N_OVERSAMPLE, N_STOP_TICKS));
   localparam int BIT_W  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

   localparam logic [TICK_W-1:0] TICK_ZERO  = TICK_W'(0);
   localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
   localparam logic [TICK_W-1:0] HALF_LAST  = TICK_W'(N_OVERSAMPLE/2 - 1);
   localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(N_OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] STOP_LAST  = TICK_W'(N_STOP_TICKS - 1);
   localparam logic [BIT_W-1:0]  BIT_ZERO   = BIT_W'(0);
   localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
   localparam logic [BIT_W-1:0]  BITS_LAST  = BIT_W'(NB_DATA - 1);

   logic                rx_s;

   state_t              state_r,    state_s;
   logic [TICK_W-1:0]   tick_cnt_r, tick_cnt_s;
   logic [BIT_W-1:0]    bit_cnt_r,  bit_cnt_s;
   logic [NB_DATA-1:0]  shift_r,    shift_s;
   logic                armed_r,    armed_s;
   logic [NB_DATA-1:0]  data_r,     data_s;
   logic                done_r,     done_s;
   logic                err_r,      err_s;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync_rx (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .d       (i_rx),
      .q       (rx_s)
   );

   // State, counters, shift register and registered outputs.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_r    <= IDLE;
         tick_cnt_r <= TICK_ZERO;
         bit_cnt_r  <= BIT_ZERO;
         shift_r    <= {NB_DATA{1'b0}};
         armed_r    <= 1'b0;
         data_r     <= {NB_DATA{1'b0}};
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         tick_cnt_r <= tick_cnt_s;
         bit_cnt_r  <= bit_cnt_s;
         shift_r    <= shift_s;
         armed_r    <= armed_s;
         data_r     <= data_s;
         done_r     <= done_s;
         err_r      <= err_s;
      end
   end

   // Next-state and datapath decisions; everything holds unless changed.
   always_comb begin
      state_s    = state_r;
      tick_cnt_s = tick_cnt_r;
      bit_cnt_s  = bit_cnt_r;
      shift_s    = shift_r;
      armed_s    = armed_r;
      data_s     = data_r;
      done_s     = 1'b0;
      err_s      = err_r;

      case (state_r)
         IDLE: begin
            // A falling edge only counts after the line has been seen high,
            // so a held-low (break) line cannot retrigger reception.
            if (rx_s) begin
               armed_s = 1'b1;
            end else if (armed_r) begin
               state_s    = START;
               tick_cnt_s = TICK_ZERO;
               armed_s    = 1'b0;
            end else begin
               armed_s = armed_r;
            end
         end

         START: begin
            if (i_tick) begin
               if (tick_cnt_r == HALF_LAST) begin
                  if (!rx_s) begin
                     state_s    = DATA;
                     tick_cnt_s = TICK_ZERO;
                     bit_cnt_s  = BIT_ZERO;
                  end else begin
                     state_s = IDLE;
                  end
               end else begin
                  tick_cnt_s = tick_cnt_r + TICK_ONE;
               end
            end else begin
               tick_cnt_s = tick_cnt_r;
            end
         end

         DATA: begin
            if (i_tick) begin
               if (tick_cnt_r == BIT_LAST) begin
                  shift_s    = {rx_s, shift_r[NB_DATA-1:1]};
                  tick_cnt_s = TICK_ZERO;
                  if (bit_cnt_r == BITS_LAST) begin
                     state_s = STOP;
                  end else begin
                     bit_cnt_s = bit_cnt_r + BIT_ONE;
                  end
               end else begin
                  tick_cnt_s = tick_cnt_r + TICK_ONE;
               end
            end else begin
               tick_cnt_s = tick_cnt_r;
            end
         end

         STOP: begin
            if (i_tick) begin
               if (tick_cnt_r == STOP_LAST) begin
                  data_s  = shift_r;
                  err_s   = ~rx_s;
                  done_s  = 1'b1;
                  state_s = IDLE;
               end else begin
                  tick_cnt_s = tick_cnt_r + TICK_ONE;
               end
            end else begin
               tick_cnt_s = tick_cnt_r;
            end
         end

         default: begin
            state_s    = IDLE;
            tick_cnt_s = TICK_ZERO;
            bit_cnt_s  = BIT_ZERO;
            armed_s    = 1'b0;
         end
      endcase
   end

   assign o_rx_data   = data_r;
   assign o_rx_done   = done_r;
   assign o_frame_err = err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are queued as they are
// sent, and a monitor compares each done pulse against the queue head.
module tb_uart_rx;

   logic       clock = 1'b0;
   logic       reset;
   logic       rx;
   logic       tick;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;

   typedef struct {
      logic [7:0] d;
      logic       err;
      int         t0;
      bit         timed;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   gate     = 1'b0;
   bit   ph       = 1'b0;

   uart_rx dut (
      .i_clock     (clock),
      .i_reset     (reset),
      .i_rx        (rx),
      .i_tick      (tick),
      .o_rx_data   (rx_data),
      .o_rx_done   (rx_done),
      .o_frame_err (frame_err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Baud tick every second clock, suppressed while gate is set.
   initial begin
      tick = 1'b0;
      forever begin
         @(negedge clock);
         tick = ph & ~gate;
         ph   = ~ph;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         while (!tick) @(posedge clock);
      end
   endtask

   task automatic drive_bit(input bit v, input int nt);
      @(negedge clock);
      rx = v;
      wait_ticks(nt);
   endtask

   // Expected result of a frame: the byte itself, error when stop bit is 0.
   task automatic send_frame(input logic [7:0] d, input bit stop, input bit timed);
      exp_q.push_back('{d, ~stop, cyc, timed});
      drive_bit(1'b0, 16);
      for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
      drive_bit(stop, 16);
   endtask

   // Monitor: each done pulse must match the oldest outstanding frame.
   initial begin
      exp_t e;
      int   lat;
      bit   prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clock);
         if (rx_done) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got data %0h, expected no frame", rx_data);
            end else begin
               e = exp_q.pop_front();
               check("rx_data", {24'd0, rx_data}, {24'd0, e.d});
               check("frame_err", {31'd0, frame_err}, {31'd0, e.err});
               if (e.timed) begin
                  lat = cyc - e.t0;
                  n_checks++;
                  if (lat < 296 || lat > 316) begin
                     n_fail++;
                     $display("FAIL done_latency: got %0d clocks, expected 296..316", lat);
                  end
               end
            end
         end
         prev_done = rx_done;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] mid;
      logic [7:0] rd;
      bit         rs;
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_data", {24'd0, rx_data}, 32'd0);
      check("reset_done", {31'd0, rx_done}, 32'd0);
      check("reset_err", {31'd0, frame_err}, 32'd0);
      reset = 1'b0;
      drive_bit(1'b1, 40);

      // Basic frame.
      send_frame(8'h35, 1'b1, 1'b1);
      drive_bit(1'b1, 32);

      // Back-to-back frames.
      send_frame(8'hA5, 1'b1, 1'b1);
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      drive_bit(1'b1, 32);

      // Framing error followed by a break, then a good frame.
      send_frame(8'h5A, 1'b0, 1'b1);
      drive_bit(1'b0, 320);
      drive_bit(1'b1, 32);
      send_frame(8'h12, 1'b1, 1'b1);
      drive_bit(1'b1, 32);

      // Start glitch, then a good frame.
      drive_bit(1'b0, 4);
      drive_bit(1'b1, 32);
      send_frame(8'hC3, 1'b1, 1'b1);
      drive_bit(1'b1, 32);

      // Reset in the middle of data bit 4 of 0x77.
      mid = 8'h77;
      drive_bit(1'b0, 16);
      for (int i = 0; i < 4; i++) drive_bit(mid[i], 16);
      drive_bit(mid[4], 8);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midreset_data", {24'd0, rx_data}, 32'd0);
      check("midreset_done", {31'd0, rx_done}, 32'd0);
      check("midreset_err", {31'd0, frame_err}, 32'd0);
      reset = 1'b0;
      rx    = 1'b1;
      drive_bit(1'b1, 48);
      send_frame(8'h81, 1'b1, 1'b1);
      drive_bit(1'b1, 32);

      // Ticks withheld for 50 clocks in the middle of a bit.
      fork
         send_frame(8'h3C, 1'b1, 1'b0);
         begin
            repeat (32*3 + 11) @(negedge clock);
            gate = 1'b1;
            repeat (50) @(negedge clock);
            gate = 1'b0;
         end
      join
      drive_bit(1'b1, 32);

      // Random frames with occasional framing errors and random gaps.
      for (int k = 0; k < 12; k++) begin
         rd = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         send_frame(rd, rs, 1'b1);
         if (!rs) drive_bit(1'b1, 32);
         else     drive_bit(1'b1, $urandom_range(0, 40));
      end

      drive_bit(1'b1, 64);
      check("all_frames_received", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
